// File: rtl/ext_pipe.sv
// Immediate extender for the D->E boundary of the MIPS core.
// Front end picks sign/zero/shamt/LUI/branch form; DEPTH registers retime it.
module ext_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5,
  parameter int DEPTH   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2:0]         ext_op,
  input  logic [IMM_W-1:0]   imm,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [DATA_W-1:0]  ext,
  output logic               op_err
);

  logic [DATA_W-1:0] w_sx;
  logic [DATA_W-1:0] w_raw;
  logic              w_err;

  logic              r_vld  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_err  [DEPTH];

  assign w_sx = DATA_W'($signed(imm));

  always_comb begin
    w_raw = '0;
    w_err = 1'b0;
    case (ext_op)
      3'd0: w_raw = w_sx;
      3'd1: w_raw = DATA_W'(imm);
      3'd2: w_raw = DATA_W'(shamt);
      3'd3: w_raw = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'd4: w_raw = w_sx << 2;
      default: w_err = 1'b1;
    endcase
    // Invalid entries never carry data or an error flag.
    if (!in_valid) begin
      w_raw = '0;
      w_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_err[k]  <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_err[k]  <= 1'b0;
      end
    end else if (!stall) begin
      r_vld[0]  <= in_valid;
      r_data[0] <= w_raw;
      r_err[0]  <= w_err;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_data[k] <= r_data[k-1];
        r_err[k]  <= r_err[k-1];
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign ext       = r_data[DEPTH-1];
  assign op_err    = r_err[DEPTH-1];

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: DEPTH 1/2/3 at 32 bits and DEPTH 4 at 64 bits.
// All four instances share inputs; each scenario checks its own instance.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  ext_op;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        stall;
  logic        flush;

  logic        v1, v2, v3, v4;
  logic        e1, e2, e3, e4;
  logic [31:0] x1, x2, x3;
  logic [63:0] x4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ext_pipe #(.DATA_W(32), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ext_op(ext_op),
    .imm(imm), .shamt(shamt), .stall(stall), .flush(flush),
    .out_valid(v1), .ext(x1), .op_err(e1));
  ext_pipe #(.DATA_W(32), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ext_op(ext_op),
    .imm(imm), .shamt(shamt), .stall(stall), .flush(flush),
    .out_valid(v2), .ext(x2), .op_err(e2));
  ext_pipe #(.DATA_W(32), .DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ext_op(ext_op),
    .imm(imm), .shamt(shamt), .stall(stall), .flush(flush),
    .out_valid(v3), .ext(x3), .op_err(e3));
  ext_pipe #(.DATA_W(64), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ext_op(ext_op),
    .imm(imm), .shamt(shamt), .stall(stall), .flush(flush),
    .out_valid(v4), .ext(x4), .op_err(e4));

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [15:0] im;
    logic [4:0]  sh;
    logic        xv;
    logic [31:0] xd;
    logic        xe;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [15:0] im);
    in_valid = v;
    ext_op   = op;
    imm      = im;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1'b0, 3'd0, 16'h0);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 3'd0, 16'h8001, 5'h00, 1'b1, 32'hFFFF8001, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 16'h8001, 5'h00, 1'b1, 32'h00008001, 1'b0};
    tbl[2]  = '{1'b1, 3'd2, 16'h8001, 5'h1F, 1'b1, 32'h0000001F, 1'b0};
    tbl[3]  = '{1'b1, 3'd3, 16'h1234, 5'h00, 1'b1, 32'h12340000, 1'b0};
    tbl[4]  = '{1'b1, 3'd4, 16'hFFFF, 5'h00, 1'b1, 32'hFFFFFFFC, 1'b0};
    tbl[5]  = '{1'b1, 3'd4, 16'h0010, 5'h00, 1'b1, 32'h00000040, 1'b0};
    tbl[6]  = '{1'b1, 3'd6, 16'h1234, 5'h03, 1'b1, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 3'd5, 16'hFFFF, 5'h1F, 1'b1, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b1, 3'd7, 16'h8000, 5'h01, 1'b1, 32'h00000000, 1'b1};
    tbl[9]  = '{1'b0, 3'd6, 16'hFFFF, 5'h1F, 1'b0, 32'h00000000, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 16'h8001, 5'h00, 1'b0, 32'h00000000, 1'b0};
    tbl[11] = '{1'b1, 3'd4, 16'h8000, 5'h00, 1'b1, 32'hFFFE0000, 1'b0};

    shamt = 5'h0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0);
    reset = 1'b1;
    #1;
    chk("rst_v1", 64'(v1), 64'd0);
    chk("rst_x1", 64'(x1), 64'd0);
    chk("rst_e1", 64'(e1), 64'd0);
    chk("rst_v4", 64'(v4), 64'd0);
    chk("rst_x4", x4, 64'd0);
    #1;
    reset = 1'b0;

    // DEPTH=1 table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vld, tbl[i].op, tbl[i].im);
      shamt = tbl[i].sh;
      step();
      chk($sformatf("d1_v[%0d]", i), 64'(v1), 64'(tbl[i].xv));
      chk($sformatf("d1_x[%0d]", i), 64'(x1), 64'(tbl[i].xd));
      chk($sformatf("d1_e[%0d]", i), 64'(e1), 64'(tbl[i].xe));
    end
    shamt = 5'h0;

    // DEPTH=3 stream with a two-cycle stall
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'd1, 16'(i));
      step();
      if (i < 3) chk($sformatf("d3_fill_v%0d", i), 64'(v3), 64'd0);
    end
    chk("d3_e3_v", 64'(v3), 64'd1);
    chk("d3_e3_x", 64'(x3), 64'd1);
    drive(1'b0, 3'd0, 16'h0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("d3_stall_v%0d", i), 64'(v3), 64'd1);
      chk($sformatf("d3_stall_x%0d", i), 64'(x3), 64'd1);
    end
    stall = 1'b0;
    step();
    chk("d3_e6_x", 64'(x3), 64'd2);
    chk("d3_e6_v", 64'(v3), 64'd1);
    step();
    chk("d3_e7_x", 64'(x3), 64'd3);
    step();
    chk("d3_e8_v", 64'(v3), 64'd0);
    chk("d3_e8_x", 64'(x3), 64'd0);

    // DEPTH=3 flush+stall squashes everything
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd6, 16'(16'h10 + i));
      step();
    end
    chk("fl_pre_v", 64'(v3), 64'd1);
    chk("fl_pre_e", 64'(e3), 64'd1);
    drive(1'b1, 3'd1, 16'h0099);
    flush = 1'b1;
    stall = 1'b1;
    step();
    chk("fl_v0", 64'(v3), 64'd0);
    chk("fl_x0", 64'(x3), 64'd0);
    chk("fl_e0", 64'(e3), 64'd0);
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 3'd0, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("fl_v%0d", i), 64'(v3), 64'd0);
      chk($sformatf("fl_x%0d", i), 64'(x3), 64'd0);
    end

    // DEPTH=2 asynchronous reset between edges
    do_reset();
    drive(1'b1, 3'd7, 16'h0005);
    step();
    drive(1'b0, 3'd0, 16'h0);
    step();
    chk("ar_pre_v", 64'(v2), 64'd1);
    chk("ar_pre_e", 64'(e2), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_v", 64'(v2), 64'd0);
    chk("ar_x", 64'(x2), 64'd0);
    chk("ar_e", 64'(e2), 64'd0);
    reset = 1'b0;
    drive(1'b1, 3'd0, 16'h7FFF);
    step();
    drive(1'b0, 3'd0, 16'h0);
    chk("ar_e1_v", 64'(v2), 64'd0);
    step();
    chk("ar_e2_v", 64'(v2), 64'd1);
    chk("ar_e2_x", 64'(x2), 64'h7FFF);

    // DEPTH=4, 64-bit datapath
    do_reset();
    drive(1'b1, 3'd0, 16'h8000);
    step();
    drive(1'b1, 3'd3, 16'hABCD);
    step();
    drive(1'b1, 3'd4, 16'h8000);
    step();
    drive(1'b0, 3'd0, 16'h0);
    chk("w64_e3_v", 64'(v4), 64'd0);
    step();
    chk("w64_e4_v", 64'(v4), 64'd1);
    chk("w64_e4_x", x4, 64'hFFFFFFFFFFFF8000);
    step();
    chk("w64_e5_x", x4, 64'hABCD000000000000);
    step();
    chk("w64_e6_x", x4, 64'hFFFFFFFFFFFE0000);
    step();
    chk("w64_e7_v", 64'(v4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Registered, parametrised immediate extender for the D→E boundary of the pipelined MIPS core. It adds LUI placement and branch-offset modes on top of sign, zero and shamt extension. Results pass through a configurable-depth register pipeline with valid tracking, stall (freeze) and flush (squash), so extension can be retimed out of the D-stage critical path.

## Interface
Parameters:
- DATA_W, 32, output datapath width; must satisfy DATA_W ≥ IMM_W+2 and DATA_W ≥ SHAMT_W
- IMM_W, 16, immediate field width
- SHAMT_W, 5, shift-amount field width
- DEPTH, 1, number of register stages, legal range 1..4

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all stages immediately
- in_valid  in  1  current D-stage instruction needs an extended immediate
- ext_op  in  3  mode select; see Operation
- imm  in  IMM_W  immediate field
- shamt  in  SHAMT_W  shift-amount field
- stall  in  1  freeze every stage (hazard stall)
- flush  in  1  squash every stage (branch/exception)
- out_valid  out  1  ext holds a valid result
- ext  out  DATA_W  extended value from the last stage
- op_err  out  1  last-stage result came from an illegal ext_op (5..7)

## Operation
- Combinational front end computes raw from ext_op:
  - 0: sign-extend imm to DATA_W
  - 1: zero-extend imm
  - 2: zero-extend shamt
  - 3: LUI, imm in top IMM_W bits, low DATA_W-IMM_W bits zero
  - 4: branch offset, sign-extend imm then shift left 2, truncated to DATA_W
  - 5..7: raw = 0 and err = 1
- Stage 0 captures {in_valid, raw, err}. Stage k captures stage k-1. The outputs come from stage DEPTH-1.
- Invalid entries always carry data 0 and err 0. When in_valid=0, stage 0 loads zeros regardless of ext_op.
- Per-edge priority: flush > stall > advance.
  - flush: every stage loads valid=0, data=0, err=0. The simultaneous input is dropped.
  - stall (no flush): every stage holds. The input is not captured and must be re-presented by the upstream.
  - Otherwise every stage advances by one.
- No backpressure output. The upstream owns stall.

## Timing
- Reset, asynchronous: out_valid=0, ext=0, op_err=0, all stages cleared, effective without a clock edge. Reset asserted mid-operation discards all in-flight entries.
- Latency: input accepted on edge N appears on outputs after edge N+DEPTH-1 (DEPTH=1: visible right after the capturing edge). Each stall cycle adds one cycle.
- Throughput: one result per non-stalled cycle.
- Flush takes effect at the edge where it is sampled. All outputs read 0 after that edge.
- Stall released: the pipeline resumes advancing on the next edge with contents intact.
- Back-to-back flush+stall in the same cycle behaves as flush.
- Outputs are purely registered (no combinational path from inputs to outputs).

## Test plan
- DEPTH=1, in_valid=1, op0, imm=16'h8001 → after one edge ext=32'hFFFF8001, out_valid=1. Then op1, same imm → 32'h00008001. Then op2, shamt=5'h1F → 32'h0000001F.
- DEPTH=1: op3, imm=16'h1234 → ext=32'h12340000. Op4, imm=16'hFFFF → 32'hFFFFFFFC. Op4, imm=16'h0010 → 32'h00000040. Op6 → ext=0, op_err=1, out_valid=1.
- DEPTH=3: stream op1 with imm 1,2,3 on consecutive cycles → ext=1,2,3 on the 3rd,4th,5th edges. Stall on the 4th cycle for 2 cycles → outputs hold, sequence resumes unchanged with no duplicate or lost value.
- DEPTH=3: pipeline holding three valid entries, assert flush and stall together one cycle → next edge out_valid=0, ext=0. Following two edges also invalid, the input presented during flush never appears.
- DEPTH=2: assert reset asynchronously between edges while out_valid=1 → out_valid, ext, op_err go to 0 before the next edge. After deassertion, a fresh op0, imm=16'h7FFF → 32'h00007FFF after 2 edges.
- DEPTH=4, DATA_W=64: op0 imm=16'h8000 → 64'hFFFFFFFFFFFF8000. Op3 imm=16'hABCD → 64'hABCD000000000000, both after 4 edges.
